// File: rtl/beacon_pkg.sv
// beacon_pkg: shared codes, channel indices, state enum and detector thresholds
package beacon_pkg;
   localparam logic [1:0] CODE_OFF = 2'b00;
   localparam logic [1:0] CODE_FRIENDLY = 2'b01;
   localparam logic [1:0] CODE_ENEMY = 2'b10;
   localparam logic [1:0] CH_FORWARD = 2'd0;
   localparam logic [1:0] CH_RIGHT = 2'd1;
   localparam logic [1:0] CH_LEFT = 2'd2;
   localparam int DEFAULT_FRIENDLY_HALF = 125000;
   localparam int DEFAULT_ENEMY_HALF = 41667;
   // rising edges per detector window that classify as friendly / enemy
   localparam int FRIENDLY_MIN_EDGES = 8;
   localparam int FRIENDLY_MAX_EDGES = 33;
   localparam int ENEMY_MIN_EDGES = 34;
   localparam int ENEMY_MAX_EDGES = 90;
   typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_SWITCH} chan_state_t;
   function automatic logic is_tone(logic [1:0] c);
      return c == CODE_FRIENDLY || c == CODE_ENEMY;
   endfunction
endpackage

// File: rtl/beacon_frequency_generator_if.sv
// beacon_frequency_generator_if: command handshake between controller and beacon
interface beacon_frequency_generator_if;
   logic cmd_valid;
   logic cmd_ready;
   logic [1:0] cmd_channel;
   logic [1:0] cmd_code;
   logic cmd_error;
   modport master (output cmd_valid, cmd_channel, cmd_code, input cmd_ready, cmd_error);
   modport slave (input cmd_valid, cmd_channel, cmd_code, output cmd_ready, cmd_error);
endinterface

// File: rtl/beacon_channel.sv
// beacon_channel: one square-wave pin whose code changes only where a rise would occur
module beacon_channel
   import beacon_pkg::*;
#(
   parameter int FRIENDLY_HALF = DEFAULT_FRIENDLY_HALF,
   parameter int ENEMY_HALF = DEFAULT_ENEMY_HALF
) (
   input logic clock,
   input logic reset,
   input logic cmd_go,
   input logic [1:0] cmd_code,
   output logic ready,
   output logic busy,
   output logic out,
   output logic [1:0] code
);
   localparam int W = $clog2(FRIENDLY_HALF > ENEMY_HALF ? FRIENDLY_HALF : ENEMY_HALF);
   localparam logic [W-1:0] F_RELOAD = W'(FRIENDLY_HALF - 1);
   localparam logic [W-1:0] E_RELOAD = W'(ENEMY_HALF - 1);
   chan_state_t state;
   logic [W-1:0] cnt;
   logic [1:0] pending;
   logic [W-1:0] run_reload, cmd_reload, pend_reload;
   assign run_reload = code == CODE_ENEMY ? E_RELOAD : F_RELOAD;
   assign cmd_reload = cmd_code == CODE_ENEMY ? E_RELOAD : F_RELOAD;
   assign pend_reload = pending == CODE_ENEMY ? E_RELOAD : F_RELOAD;
   assign ready = state != ST_SWITCH;
   assign busy = state == ST_SWITCH;
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_OFF;
         cnt <= '0;
         out <= 1'b0;
         code <= CODE_OFF;
         pending <= CODE_OFF;
      end else begin
         case (state)
            ST_OFF:
               if (cmd_go && is_tone(cmd_code)) begin
                  code <= cmd_code;
                  cnt <= cmd_reload;
                  out <= 1'b1;
                  state <= ST_RUN;
               end
            ST_RUN: begin
               cnt <= cnt == '0 ? run_reload : cnt - 1'b1;
               if (cnt == '0) out <= ~out;
               if (cmd_go && cmd_code != code) begin
                  pending <= cmd_code;
                  state <= ST_SWITCH;
               end
            end
            ST_SWITCH:
               // the switch point is where the running waveform would rise next
               if (cnt != '0) cnt <= cnt - 1'b1;
               else if (out) begin
                  out <= 1'b0;
                  cnt <= run_reload;
               end else if (is_tone(pending)) begin
                  code <= pending;
                  out <= 1'b1;
                  cnt <= pend_reload;
                  state <= ST_RUN;
               end else begin
                  code <= CODE_OFF;
                  state <= ST_OFF;
               end
            default: state <= ST_OFF;
         endcase
      end
   end
endmodule

// File: rtl/beacon_frequency_generator.sv
// beacon_frequency_generator: three-channel beacon with command decode, ready mux and error pulse
module beacon_frequency_generator
   import beacon_pkg::*;
#(
   parameter int FRIENDLY_HALF = DEFAULT_FRIENDLY_HALF,
   parameter int ENEMY_HALF = DEFAULT_ENEMY_HALF
) (
   input logic clock,
   input logic reset,
   beacon_frequency_generator_if.slave cmd,
   output logic forward_out,
   output logic right_out,
   output logic left_out,
   output logic [1:0] forward_code,
   output logic [1:0] right_code,
   output logic [1:0] left_code,
   output logic [2:0] busy
);
   logic [3:0] ready;
   logic [2:0] outs;
   logic [1:0] codes [3];
   logic error;
   // the invalid channel always accepts so a bad command can never stall the bus
   assign ready[3] = 1'b1;
   assign cmd.cmd_ready = ready[cmd.cmd_channel];
   assign cmd.cmd_error = error;
   for (genvar i = 0; i < 3; i++) begin : g_ch
      beacon_channel #(.FRIENDLY_HALF(FRIENDLY_HALF), .ENEMY_HALF(ENEMY_HALF)) u_ch (
         .clock(clock),
         .reset(reset),
         .cmd_go(cmd.cmd_valid && cmd.cmd_channel == 2'(i) && ready[i]),
         .cmd_code(cmd.cmd_code),
         .ready(ready[i]),
         .busy(busy[i]),
         .out(outs[i]),
         .code(codes[i])
      );
   end
   always_ff @(posedge clock) error <= reset ? 1'b0 : cmd.cmd_valid && cmd.cmd_channel == 2'b11;
   assign forward_out = outs[CH_FORWARD];
   assign right_out = outs[CH_RIGHT];
   assign left_out = outs[CH_LEFT];
   assign forward_code = codes[CH_FORWARD];
   assign right_code = codes[CH_RIGHT];
   assign left_code = codes[CH_LEFT];
endmodule

// File: tb/tb_beacon_frequency_generator.sv
// tb_beacon_frequency_generator: directed and random commands against a waveform-timing model
module tb_beacon_frequency_generator;
   localparam int FH = 10;
   localparam int EH = 4;
   logic clock = 1'b0;
   logic reset;
   logic forward_out, right_out, left_out;
   logic [1:0] forward_code, right_code, left_code;
   logic [2:0] busy;
   beacon_frequency_generator_if bus ();
   beacon_frequency_generator #(.FRIENDLY_HALF(FH), .ENEMY_HALF(EH)) dut (
      .clock(clock),
      .reset(reset),
      .cmd(bus),
      .forward_out(forward_out),
      .right_out(right_out),
      .left_out(left_out),
      .forward_code(forward_code),
      .right_code(right_code),
      .left_code(left_code),
      .busy(busy)
   );
   always #5 clock = ~clock;
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   // model: active code, edge of the most recent fresh rise, queued code
   int m_act [4];
   int m_start [4];
   int m_pend [4];
   bit m_hp [4];
   bit m_err;
   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
      end
   endtask
   function automatic bit tone(input int c);
      return c == 1 || c == 2;
   endfunction
   function automatic int half_of(input int c);
      return c == 2 ? EH : FH;
   endfunction
   function automatic int level(input int c);
      if (!tone(m_act[c])) return 0;
      return ((cyc - m_start[c]) / half_of(m_act[c])) % 2 == 0 ? 1 : 0;
   endfunction
   task automatic model_step(input bit r, input bit acc, input int ch, input int cd);
      if (r) begin
         for (int c = 0; c < 4; c++) begin
            m_act[c] = 0;
            m_start[c] = 0;
            m_pend[c] = 0;
            m_hp[c] = 0;
         end
         m_err = 0;
         return;
      end
      m_err = acc && ch == 3;
      for (int c = 0; c < 3; c++) begin
         int ph;
         ph = cyc - m_start[c];
         if (m_hp[c] && tone(m_act[c]) && ph > 0 && ph % (2 * half_of(m_act[c])) == 0) begin
            m_act[c] = tone(m_pend[c]) ? m_pend[c] : 0;
            m_start[c] = cyc;
            m_hp[c] = 0;
         end
      end
      if (acc && ch < 3) begin
         if (!tone(m_act[ch])) begin
            if (tone(cd)) begin
               m_act[ch] = cd;
               m_start[ch] = cyc;
            end
         end else if (cd != m_act[ch]) begin
            m_pend[ch] = cd;
            m_hp[ch] = 1;
         end
      end
   endtask
   task automatic cycle(input bit r, input bit v, input int ch, input int cd);
      bit exp_ready;
      reset = r;
      bus.cmd_valid = v;
      bus.cmd_channel = 2'(ch);
      bus.cmd_code = 2'(cd);
      #1;
      exp_ready = ch == 3 ? 1'b1 : !m_hp[ch];
      chk("cmd_ready", int'(bus.cmd_ready), int'(exp_ready));
      @(posedge clock);
      cyc++;
      model_step(r, v && exp_ready, ch, cd);
      #1;
      chk("forward_out", int'(forward_out), level(0));
      chk("right_out", int'(right_out), level(1));
      chk("left_out", int'(left_out), level(2));
      chk("forward_code", int'(forward_code), m_act[0]);
      chk("right_code", int'(right_code), m_act[1]);
      chk("left_code", int'(left_code), m_act[2]);
      chk("busy", int'(busy), {29'd0, m_hp[2], m_hp[1], m_hp[0]});
      chk("cmd_error", int'(bus.cmd_error), int'(m_err));
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 0);
   endtask
   initial begin
      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_channel = 2'd0;
      bus.cmd_code = 2'd0;
      model_step(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      idle(100);
      cycle(0, 1, 0, 1);
      idle(45);
      cycle(0, 1, 1, 2);
      idle(2);
      cycle(0, 1, 1, 1);
      cycle(0, 1, 1, 2);
      cycle(0, 1, 1, 0);
      idle(30);
      cycle(0, 1, 2, 1);
      idle(5);
      cycle(0, 1, 2, 0);
      idle(40);
      cycle(0, 1, 3, 1);
      idle(3);
      cycle(0, 1, 0, 1);
      cycle(0, 1, 1, 2);
      cycle(0, 1, 2, 1);
      idle(3);
      cycle(0, 1, 0, 2);
      cycle(0, 1, 1, 1);
      cycle(0, 1, 2, 3);
      idle(2);
      cycle(1, 0, 0, 0);
      idle(30);
      for (int k = 0; k < 3000; k++)
         cycle($urandom % 400 == 0, $urandom % 6 == 0, int'($urandom % 4), int'($urandom % 4));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
